// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: active-low {g,f,e,d,c,b,a} patterns, digit
// codes and one-hot-low anode values used by both the display encoder and capture.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [3:0] CODE_DASH = 4'd10;
    localparam logic [3:0] CODE_BAD  = 4'd15;

    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;

    typedef struct packed {
        logic [3:0] an;
        logic       dp;
        logic [6:0] seg;
    } sample_t;

    // {valid, slot}; anything other than a single low anode is idle.
    function automatic logic [2:0] an_slot(input logic [3:0] an);
        case (an)
            AN_SLOT0: return 3'b100;
            AN_SLOT1: return 3'b101;
            AN_SLOT2: return 3'b110;
            AN_SLOT3: return 3'b111;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational active-low segment pattern to digit code decoder; unknown
// patterns map to CODE_BAD with bad raised.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       bad
);

    always_comb begin
        code = CODE_BAD;
        bad  = 1'b0;
        case (seg)
            SEG_0:    code = 4'd0;
            SEG_1:    code = 4'd1;
            SEG_2:    code = 4'd2;
            SEG_3:    code = 4'd3;
            SEG_4:    code = 4'd4;
            SEG_5:    code = 4'd5;
            SEG_6:    code = 4'd6;
            SEG_7:    code = 4'd7;
            SEG_8:    code = 4'd8;
            SEG_9:    code = 4'd9;
            SEG_DASH: code = CODE_DASH;
            default:  bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures a multiplexed seven-segment display back into a 4-digit frame.
// Define SSEG_CAPTURE_ORDER_CHECK_EN to enforce slot 0,1,2,3 scan order.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int SETTLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       dp,
    input  logic [3:0] an,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp_out,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       seq_err
);

    localparam int CW = $clog2(SETTLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLING, S_CAPTURED} state_t;

    sample_t samp_q, prev_q;
    state_t  state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [2:0] slot_info;
    logic [1:0] slot;
    logic       stable, capture;
    logic [3:0] code;
    logic       bad;

    logic [3:0][3:0] stage_q, stage_nxt, dig_q;
    logic [3:0]      sdp_q, sdp_nxt, dp_q, mask_q, mask_nxt;
    logic            publish, wr, seq_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            samp_q <= '0;
            prev_q <= '0;
        end else begin
            samp_q <= '{an: an, dp: dp, seg: {g, f, e, d, c, b, a}};
            prev_q <= samp_q;
        end
    end

    assign slot_info = an_slot(samp_q.an);
    assign slot      = slot_info[1:0];
    assign stable    = slot_info[2] && (samp_q == prev_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        capture   = 1'b0;
        if (!stable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else if (state_q != S_CAPTURED) begin
            if (cnt_q == CNT_MAX) begin
                capture   = 1'b1;
                state_nxt = S_CAPTURED;
            end else begin
                state_nxt = S_SETTLING;
                cnt_nxt   = cnt_q + 1'b1;
            end
        end
    end

    sevenseg_pattern_decode u_dec (
        .seg  (samp_q.seg),
        .code (code),
        .bad  (bad)
    );

    assign seg_err = capture & bad;

    always_comb begin
        stage_nxt = stage_q;
        sdp_nxt   = sdp_q;
        mask_nxt  = mask_q;
        seq_nxt   = 1'b0;
        wr        = capture;
`ifdef SSEG_CAPTURE_ORDER_CHECK_EN
        // mask is always a prefix in ordered mode, so the next slot is its popcount.
        if (capture && slot != (mask_q[2] ? 2'd3 : mask_q[1] ? 2'd2 : mask_q[0] ? 2'd1 : 2'd0)) begin
            seq_nxt  = 1'b1;
            mask_nxt = '0;
            wr       = (slot == 2'd0);
        end
`endif
        if (wr) begin
            stage_nxt[slot] = code;
            sdp_nxt[slot]   = ~samp_q.dp;
            mask_nxt[slot]  = 1'b1;
        end
        publish = &mask_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q     <= '0;
            sdp_q       <= '0;
            mask_q      <= '0;
            dig_q       <= '0;
            dp_q        <= '0;
            frame_valid <= 1'b0;
        end else begin
            stage_q     <= stage_nxt;
            sdp_q       <= sdp_nxt;
            mask_q      <= publish ? 4'b0000 : mask_nxt;
            frame_valid <= publish;
            if (publish) begin
                dig_q <= stage_nxt;
                dp_q  <= sdp_nxt;
            end
        end
    end

`ifdef SSEG_CAPTURE_ORDER_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) seq_err <= 1'b0;
        else       seq_err <= seq_nxt;
    end
`else
    assign seq_err = 1'b0;
`endif

    assign digit0 = dig_q[0];
    assign digit1 = dig_q[1];
    assign digit2 = dig_q[2];
    assign digit3 = dig_q[3];
    assign dp_out = dp_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: table of scan vectors plus latency
// and reset-mid-frame sequences.
module tb_sevenseg_capture;

    logic clock = 1'b0;
    logic reset;
    logic a, b, c, d, e, f, g, dp;
    logic [3:0] an;
    logic [3:0] digit0, digit1, digit2, digit3, dp_out;
    logic frame_valid, seg_err, seq_err;

    int checks = 0;
    int errors = 0;
    int nframe = 0, nseg = 0, nseq = 0;

    always #5 clock = ~clock;

    sevenseg_capture #(.SETTLE(16)) dut (
        .clock(clock), .reset(reset),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dp_out(dp_out), .frame_valid(frame_valid), .seg_err(seg_err), .seq_err(seq_err)
    );

    always @(negedge clock) begin
        if (!reset) begin
            if (frame_valid) nframe <= nframe + 1;
            if (seg_err)     nseg   <= nseg + 1;
            if (seq_err)     nseq   <= nseq + 1;
        end
    end

    typedef struct {
        logic [15:0] codes;
        logic [3:0]  dpo;
        logic [7:0]  order;
        int          dwell;
        bit          gaps;
        int          efr;
        logic [15:0] edig;
        logic [3:0]  edp;
        int          eseg;
        int          eseq;
    } vec_t;

    function automatic vec_t mk(logic [15:0] codes, logic [3:0] dpo, logic [7:0] order,
                                int dwell, bit gaps, int efr, logic [15:0] edig,
                                logic [3:0] edp, int eseg, int eseq);
        vec_t v;
        v.codes = codes; v.dpo = dpo; v.order = order; v.dwell = dwell; v.gaps = gaps;
        v.efr = efr; v.edig = edig; v.edp = edp; v.eseg = eseg; v.eseq = eseq;
        return v;
    endfunction

    function automatic logic [6:0] seg_of(logic [3:0] code);
        case (code)
            4'd0:  return 7'b1000000;
            4'd1:  return 7'b1111001;
            4'd2:  return 7'b0100100;
            4'd3:  return 7'b0110000;
            4'd4:  return 7'b0011001;
            4'd5:  return 7'b0010010;
            4'd6:  return 7'b0000010;
            4'd7:  return 7'b1111000;
            4'd8:  return 7'b0000000;
            4'd9:  return 7'b0010000;
            4'd10: return 7'b0111111;
            default: return 7'b1010101;
        endcase
    endfunction

    function automatic logic [3:0] an_of(int k);
        logic [3:0] t;
        t = 4'b0001 << k;
        return ~t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Pins change at a negedge and are held for n rising edges.
    task automatic drive(input logic [3:0] an_v, input logic [6:0] seg_v, input logic dp_v, input int n);
        {g, f, e, d, c, b, a} = seg_v;
        an = an_v;
        dp = dp_v;
        repeat (n) @(negedge clock);
    endtask

    task automatic show(input int k, input logic [3:0] code, input logic dpo, input int n);
        drive(an_of(k), seg_of(code), ~dpo, n);
    endtask

    task automatic blank(input int n);
        drive(4'b1111, 7'h7F, 1'b1, n);
    endtask

    task automatic chk_digits(input string tag, input logic [15:0] edig, input logic [3:0] edp);
        chk({tag, " digit0"}, int'(digit0), int'(edig[3:0]));
        chk({tag, " digit1"}, int'(digit1), int'(edig[7:4]));
        chk({tag, " digit2"}, int'(digit2), int'(edig[11:8]));
        chk({tag, " digit3"}, int'(digit3), int'(edig[15:12]));
        chk({tag, " dp_out"}, int'(dp_out), int'(edp));
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, s0, q0, k, n;
        vecs[0] = mk(16'h4321, 4'b0000, 8'hE4, 10, 0, 0, 16'h0000, 4'b0000, 0, 0);
        vecs[1] = mk(16'h4321, 4'b0000, 8'hE4, 16, 0, 0, 16'h0000, 4'b0000, 0, 0);
        vecs[2] = mk(16'h4321, 4'b0000, 8'hE4, 64, 0, 1, 16'h4321, 4'b0000, 0, 0);
        vecs[3] = mk(16'h8765, 4'b0101, 8'hE4, 17, 0, 1, 16'h8765, 4'b0101, 0, 0);
        vecs[4] = mk(16'h0FA9, 4'b0000, 8'hE4, 64, 0, 1, 16'h0FA9, 4'b0000, 1, 0);
        vecs[5] = mk(16'h1413, 4'b1000, 8'hE4, 40, 1, 1, 16'h1413, 4'b1000, 0, 0);
`ifdef SSEG_CAPTURE_ORDER_CHECK_EN
        vecs[6] = mk(16'h8172, 4'b0000, 8'hD8, 64, 0, 0, 16'h1413, 4'b1000, 0, 3);
`else
        vecs[6] = mk(16'h8172, 4'b0000, 8'hD8, 64, 0, 1, 16'h8172, 4'b0000, 0, 0);
`endif
        vecs[7] = mk(16'h8888, 4'b1111, 8'hE4, 30, 0, 1, 16'h8888, 4'b1111, 0, 0);

        reset = 1'b1;
        {a, b, c, d, e, f, g, dp} = '1;
        an = 4'b1111;
        repeat (3) @(negedge clock);
        chk_digits("reset", 16'h0000, 4'b0000);
        chk("reset frame_valid", int'(frame_valid), 0);
        chk("reset seg_err", int'(seg_err), 0);
        chk("reset seq_err", int'(seq_err), 0);
        reset = 1'b0;
        blank(2);

        for (int i = 0; i < 8; i++) begin
            f0 = nframe; s0 = nseg; q0 = nseq;
            for (int j = 0; j < 4; j++) begin
                k = int'(vecs[i].order[2*j +: 2]);
                if (vecs[i].gaps) begin
                    blank(20);
                    drive(4'b1100, seg_of(4'd3), 1'b0, 20);
                end
                show(k, vecs[i].codes[4*k +: 4], vecs[i].dpo[k], vecs[i].dwell);
            end
            blank(4);
            chk($sformatf("vec%0d frames", i), nframe - f0, vecs[i].efr);
            chk($sformatf("vec%0d seg_err", i), nseg - s0, vecs[i].eseg);
            chk($sformatf("vec%0d seq_err", i), nseq - q0, vecs[i].eseq);
            chk_digits($sformatf("vec%0d", i), vecs[i].edig, vecs[i].edp);
        end

        // Latency: frame_valid appears SETTLE+2 edges after the last slot's pattern is driven.
        for (int j = 0; j < 3; j++) show(j, 4'd0, 1'b0, 30);
        show(3, 4'd5, 1'b0, 0);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!frame_valid && n < 100);
        chk("latency edges", n, 18);
        @(negedge clock);
        blank(4);
        chk_digits("latency frame", 16'h5000, 4'b0000);

        // Reset mid-frame discards slots 0 and 1.
        show(0, 4'd6, 1'b1, 30);
        show(1, 4'd6, 1'b1, 30);
        reset = 1'b1;
        blank(3);
        chk_digits("midreset", 16'h0000, 4'b0000);
        chk("midreset frame_valid", int'(frame_valid), 0);
        reset = 1'b0;
        blank(2);
        f0 = nframe;
        show(0, 4'd4, 1'b0, 30);
        show(1, 4'd3, 1'b0, 30);
        show(2, 4'd2, 1'b0, 30);
        blank(4);
        chk("after reset 3 captures frames", nframe - f0, 0);
        chk("after reset 3 captures digit0", int'(digit0), 0);
        show(3, 4'd1, 1'b0, 30);
        blank(4);
        chk("after reset 4 captures frames", nframe - f0, 1);
        chk_digits("after reset", 16'h1234, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side counterpart of the `sevenseg` display multiplexer. It watches the multiplexed segment and anode lines (`a`..`g`, `dp`, `an[3:0]`), waits for each anode dwell to settle, and decodes the active-low segment pattern back to a 4-bit digit code. It assembles the four decoded digits into a frame and publishes the frame atomically with a one-cycle strobe. It sits in self-test and loopback paths, and in any block that must read back what the display is showing.

## Interface
- `SETTLE`, 16: consecutive identical samples required before capture; minimum 2.
- `clock` in 1: sole clock; all inputs are synchronous to it.
- `reset` in 1: synchronous, active-high.
- `a`,`b`,`c`,`d`,`e`,`f`,`g` in 1 each: segment lines, active low.
- `dp` in 1: decimal point, active low.
- `an` in 4: digit enables, active low, one-hot-low when valid.
- `digit0`..`digit3` out 4 each: published digit codes; `digitk` is the slot enabled by `an[k]`=0.
- `dp_out` out 4: published decimal points, active high, bit k = slot k.
- `frame_valid` out 1: one-cycle pulse when new `digit*`/`dp_out` values take effect.
- `seg_err` out 1: one-cycle pulse when an unrecognised segment pattern is captured.
- `seq_err` out 1: one-cycle pulse on a scan-order violation (see Configuration).

## Operation
- One input register stage samples `{an, dp, g,f,e,d,c,b,a}` (12 bits).
- `an` is valid only when it is 1110, 1101, 1011 or 0111, giving slot 0..3. Any other value (including the 1111 blank) is idle.
- State machine:
  - IDLE: the sample is idle, or it differs from the previous sample. The stability counter is cleared.
  - SETTLING: the sample is valid and unchanged. The counter increments.
  - CAPTURED: the counter reached `SETTLE`-1. Exactly one capture occurs. The machine holds until the sample changes, then returns to IDLE.
- Decode `{g,f,e,d,c,b,a}`:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0111111→10 (dash).
  - Any other pattern → 15, with a `seg_err` pulse.
- A capture writes the code and `~dp` into staging slot k and sets `mask[k]`.
- When `mask` becomes 1111:
  - staging is copied to the outputs and `frame_valid` pulses;
  - `mask` clears.
- Without order checking, a repeat capture of a slot already in `mask` overwrites that staging entry. No error is raised.
- Outputs change only on `frame_valid`. Partial frames are never visible.

## Timing
- Reset values:
  - `digit0`..`digit3` = 0, `dp_out` = 0;
  - `frame_valid`, `seg_err`, `seq_err` = 0;
  - `mask` = 0, state IDLE, counter 0, staging 0.
- The capture cycle is `SETTLE`+1 clocks after a new stable pattern appears on the pins: 1 for the input register, then `SETTLE` to settle.
- `seg_err` pulses in the capture cycle.
- `frame_valid`, `seq_err` and the updated outputs appear one clock after the capture that triggers them.
- A sample change in the same cycle the counter would reach `SETTLE`-1 aborts the capture.
- Reset mid-frame discards staging and `mask`. The first frame after reset needs four fresh captures.

## Configuration
- `SSEG_CAPTURE_ORDER_CHECK_EN` defined:
  - A frame must be slots 0,1,2,3 in that order, matching the driver scan order.
  - A frame starts only at slot 0.
  - Any capture that is not the expected next slot pulses `seq_err` and clears `mask`. If that capture is slot 0, it then starts a new frame.
  - A capture arriving with `mask` empty that is not slot 0 is ignored and pulses `seq_err`.
- Undefined: any order is accepted, and `seq_err` is tied 0.

## Structure
- Shared package `sevenseg_pkg`:
  - the 7-bit segment pattern constants for codes 0–10;
  - the `CODE_DASH` (10) and `CODE_BAD` (15) constants;
  - the one-hot-low anode constants for slots 0–3.
- The encoder and decoder share these constants.
- One sub-module, `sevenseg_pattern_decode`, is a combinational 7→4 decoder with a `bad` flag.
- Counter width is `$clog2(SETTLE)`.

## Test plan
- Driver model scanning digits 1,2,3,4 with dwell 64 and `SETTLE`=16 → `frame_valid` each full scan; `digit0..3` = 1,2,3,4; `dp_out` = 0.
- Dwell 10 < `SETTLE` → no capture; `frame_valid` never asserts; outputs stay 0.
- Slot 2 showing 1010101 → `seg_err` pulse; `digit2` = 15 after that frame.
- `an` = 1111 and 1100 inserted between dwells → ignored; frames still complete correctly.
- With the macro defined, scan order 0,2,1,3 → `seq_err` on slot 2 and no `frame_valid`. With it undefined, the same order gives `frame_valid` with correct digits.
- Reset asserted after slots 0 and 1 are captured → all outputs 0; the first `frame_valid` arrives only after four new captures.
